// File: rtl/vending_machine.sv
// Rs25 vending machine with Rs5..Rs25 coins.
// Credit is held in Rs5 units; vend/change are registered one-cycle pulses.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] coin,
  output logic       vend,
  output logic [2:0] change,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    FIVE        = 3'b001,
    TEN         = 3'b010,
    FIFTEEN     = 3'b011,
    TWENTY      = 3'b100,
    TWENTY_FIVE = 3'b101
  } state_e;

  localparam logic [3:0] PRICE_U = 4'd5;

  state_e     state_q, state_d;
  logic       vend_q, vend_d;
  logic [2:0] change_q, change_d;
  logic       coin_ok;
  logic [3:0] sum;

  // Coin codes 1..5 map to Rs5..Rs25, i.e. their own Rs5 unit count.
  always_comb begin
    coin_ok = (coin != 3'd0) && (coin <= 3'd5);
    sum     = {1'b0, state_q} + {1'b0, coin};
  end

  // Next credit, vend pulse and change for the coming edge.
  always_comb begin
    state_d  = state_q;
    vend_d   = 1'b0;
    change_d = 3'd0;
    if (state_q == TWENTY_FIVE) begin
      state_d = IDLE;
    end else if (coin_ok) begin
      if (sum < PRICE_U) begin
        state_d = state_e'(sum[2:0]);
      end else begin
        vend_d   = 1'b1;
        // sum is 5..9, low bits minus 5 wrap to 0..4.
        change_d = sum[2:0] - 3'd5;
        state_d  = IDLE;
      end
    end
  end

  // Credit and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vend_q   <= 1'b0;
      change_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      vend_q   <= vend_d;
      change_q <= change_d;
    end
  end

  assign state  = state_q;
  assign vend   = vend_q;
  assign change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine.
// Vector table plus hand-written async reset checks.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [2:0] coin;
  logic       vend;
  logic [2:0] change;
  logic [2:0] state;

  int n_vec;
  int n_bad;

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .coin   (coin),
    .vend   (vend),
    .change (change),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] coin;
    logic [2:0] st;
    logic       vd;
    logic [2:0] ch;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] c,
                     input logic [2:0] s, input logic v,
                     input logic [2:0] h, input string nm);
    vec_t e;
    e.rst = r; e.coin = c; e.st = s; e.vd = v; e.ch = h; e.name = nm;
    tbl.push_back(e);
  endtask

  task automatic check(input string nm, input logic [2:0] s,
                       input logic v, input logic [2:0] h);
    n_vec++;
    if (state !== s || vend !== v || change !== h) begin
      n_bad++;
      $display("FAIL %s: got state=%b vend=%b change=%b, want state=%b vend=%b change=%b",
               nm, state, vend, change, s, v, h);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    coin  = 3'd0;

    add(0, 3'b000, 3'b000, 0, 3'b000, "reset");
    add(0, 3'b001, 3'b000, 0, 3'b000, "coin_in_reset");
    add(1, 3'b101, 3'b000, 1, 3'b000, "v2_25");
    add(1, 3'b000, 3'b000, 0, 3'b000, "v2_after");
    add(1, 3'b001, 3'b001, 0, 3'b000, "v3_c1");
    add(1, 3'b001, 3'b010, 0, 3'b000, "v3_c2");
    add(1, 3'b001, 3'b011, 0, 3'b000, "v3_c3");
    add(1, 3'b001, 3'b100, 0, 3'b000, "v3_c4");
    add(1, 3'b001, 3'b000, 1, 3'b000, "v3_c5");
    add(1, 3'b000, 3'b000, 0, 3'b000, "v3_after");
    add(1, 3'b010, 3'b010, 0, 3'b000, "v4_c1");
    add(1, 3'b101, 3'b000, 1, 3'b010, "v4_c2");
    add(1, 3'b001, 3'b001, 0, 3'b000, "v4_c3");
    add(1, 3'b110, 3'b001, 0, 3'b000, "v6_inv110");
    add(1, 3'b111, 3'b001, 0, 3'b000, "v6_inv111");
    add(1, 3'b100, 3'b000, 1, 3'b000, "v6_20");
    add(1, 3'b010, 3'b010, 0, 3'b000, "v5_c1");
    add(1, 3'b010, 3'b100, 0, 3'b000, "v5_c2");
    add(1, 3'b101, 3'b000, 1, 3'b100, "v5_c3");
    add(1, 3'b100, 3'b100, 0, 3'b000, "b2b_20");
    add(1, 3'b011, 3'b000, 1, 3'b010, "b2b_35");
    add(1, 3'b101, 3'b000, 1, 3'b000, "b2b_next");
    add(1, 3'b011, 3'b011, 0, 3'b000, "hold_set");
    add(1, 3'b000, 3'b011, 0, 3'b000, "hold_none");
    add(0, 3'b010, 3'b000, 0, 3'b000, "reset_discard");
    add(1, 3'b010, 3'b010, 0, 3'b000, "first_coin");

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst  = tbl[i].rst;
      coin = tbl[i].coin;
      @(posedge clk);
      #1;
      check(tbl[i].name, tbl[i].st, tbl[i].vd, tbl[i].ch);
    end

    // V-1: credit TWENTY, async reset mid-cycle clears before next edge.
    @(negedge clk);
    coin = 3'b010;
    @(posedge clk);
    #1;
    check("v1_setup", 3'b100, 1'b0, 3'b000);
    @(negedge clk);
    coin = 3'b000;
    #2;
    rst = 1'b0;
    #1;
    check("v1_async", 3'b000, 1'b0, 3'b000);

    // Async reset also kills a vend pulse in flight.
    @(negedge clk);
    rst  = 1'b1;
    coin = 3'b101;
    @(posedge clk);
    #1;
    check("vend_setup", 3'b000, 1'b1, 3'b000);
    #1;
    rst = 1'b0;
    #1;
    check("vend_async_clr", 3'b000, 1'b0, 3'b000);

    // Change pulse in flight is cleared too.
    @(negedge clk);
    rst  = 1'b1;
    coin = 3'b100;
    @(posedge clk);
    @(negedge clk);
    coin = 3'b101;
    @(posedge clk);
    #1;
    check("chg_setup", 3'b000, 1'b1, 3'b100);
    #1;
    rst = 1'b0;
    #1;
    check("chg_async_clr", 3'b000, 1'b0, 3'b000);

    @(negedge clk);
    rst  = 1'b1;
    coin = 3'b000;
    @(posedge clk);
    #1;
    check("idle_after", 3'b000, 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
- No parameters; price and coin set are fixed.
- REQ-001: clk  input  1  system clock; all state updates on rising edge.
- REQ-002: rst  input  1  asynchronous reset, active-low (rst=0 resets).
- REQ-003: coin  input  3  coin code sampled each rising clk edge:
  - 000 = none
  - 001 = Rs5, 010 = Rs10, 011 = Rs15, 100 = Rs20, 101 = Rs25
  - 110 and 111 invalid.
- REQ-004: vend  output  1  registered; 1 for exactly the cycle after the purchase completes.
- REQ-005: change  output  3  registered; change returned in the vend cycle, same encoding as coin (000 = none, 001 = Rs5 ... 100 = Rs20).
- REQ-006: state  output  3  current credit state register, driven directly.

Function
- REQ-007: Item price SHALL be Rs25; credit is tracked in Rs5 units.
- REQ-008: The state machine SHALL have six states with fixed encodings:
  - IDLE=000 (Rs0), FIVE=001, TEN=010, FIFTEEN=011, TWENTY=100, TWENTY_FIVE=101.
- REQ-009: Each rising edge with a valid nonzero coin code SHALL count as one insertion.
  - Coins are level-sampled: a code held for N cycles counts N coins.
- REQ-010: On a valid coin, sum = current credit + coin value, range Rs5..Rs45.
- REQ-011: If sum < Rs25:
  - state SHALL become the state encoding sum;
  - vend=0, change=000.
- REQ-012: If sum >= Rs25:
  - vend SHALL be 1 and change SHALL encode (sum - 25)/5 (0..4);
  - state SHALL return to IDLE, all in the same edge.
- REQ-013: TWENTY_FIVE (101) SHALL be a legal encoding but never held as a resting credit, since sum >= 25 always vends.
  - If state is ever 101, the next edge SHALL return to IDLE with vend=0 and change=000, regardless of coin.
- REQ-014: With coin=000 or an invalid code (110, 111):
  - state SHALL hold;
  - vend=0 and change=000 on that edge;
  - the invalid coin is not credited.
- REQ-015: vend and change SHALL be 0 in every cycle other than the one following a completing coin; no multi-cycle pulses.
- REQ-016: Back-to-back purchases SHALL be supported with no idle cycle.
  - A coin on the edge after a vend is credited from IDLE.
- REQ-017: Outputs SHALL be glitch-free registered values; no combinational path from coin to any output.

Reset
- REQ-018: While rst=0, asynchronously and independent of clk: state=IDLE (000), vend=0, change=000.
- REQ-019: Reset SHALL discard any partial credit (reset mid-operation), with no refund indication.
- REQ-020: coin SHALL be ignored while rst=0.
  - The first credited coin is the one sampled on the first rising edge with rst=1.

Verification
- V-1: rst=0 asynchronously, with credit at TWENTY -> state=000, vend=0, change=000 immediately, before the next edge.
- V-2: From IDLE, coin=101 for 1 cycle -> vend=1, change=000, state=000; next cycle with coin=000 -> vend=0.
- V-3: From IDLE, coin=001 held for 5 cycles -> state 001, 010, 011, 100, then vend=1, change=000, state=000.
- V-4: From IDLE, coins 010, 101, 001 on consecutive cycles:
  - cycle 1: state=010;
  - cycle 2: vend=1, change=010 (Rs10), state=000;
  - cycle 3: vend=0, state=001.
- V-5: From IDLE, coins 010, 010, 101 -> state 010, 100, then vend=1, change=100 (Rs20), state=000.
- V-6: From FIVE, coin=110 then 111 -> state stays 001, vend=0, change=000; then coin=100 -> vend=1, change=000.
